// File: rtl/gate_pkg.sv
// Shared types and the golden reduction function for the gate sweep checker.
// gate_ref zero-extends patterns to 16 bits and masks them to the active width.
package gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int MAX_N = 16;

    function automatic logic gate_ref(input logic [15:0] pattern,
                                      input logic [4:0]  width,
                                      input logic [2:0]  op);
        logic [15:0] mask;
        logic        and_r;
        logic        or_r;
        logic        xor_r;
        logic        result;
        mask  = 16'hFFFF >> (5'd16 - width);
        // Bits above the active width are forced to 1 so they do not affect AND.
        and_r = &(pattern | ~mask);
        or_r  = |(pattern & mask);
        xor_r = ^(pattern & mask);
        case (op)
            OP_AND:  result = and_r;
            OP_OR:   result = or_r;
            OP_NAND: result = ~and_r;
            OP_NOR:  result = ~or_r;
            OP_XNOR: result = ~xor_r;
            default: result = xor_r;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/gate_ref_model.sv
// Combinational reference gate: the expected output of an N-input reduction
// gate for the selected operation; reusable as a golden model elsewhere.
module gate_ref_model
    import gate_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] pattern,
    input  logic [2:0]   op,
    output logic         expected
);

    assign expected = gate_ref(16'(pattern), 5'(N), op);

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep engine: drives every N-bit pattern to a gate under test for
// HOLD cycles each and checks the response on the last hold cycle.
module gate_sweep_checker
    import gate_pkg::*;
#(
    parameter int N    = 2,
    parameter int HOLD = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    output logic [N-1:0] dut_in,
    input  logic         dut_out,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N:0]   err_count,
    output logic         fail_valid,
    output logic [N-1:0] first_fail
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [N-1:0] LAST_PATTERN = {N{1'b1}};

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [N-1:0]  pattern_q, pattern_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [N:0]    err_count_q, err_count_d;
    logic          fail_valid_q, fail_valid_d;
    logic [N-1:0]  first_fail_q, first_fail_d;
    logic          pass_q, pass_d;
    logic          expected;
    logic          sample;

    gate_ref_model #(.N(N)) u_ref (
        .pattern  (pattern_q),
        .op       (op_q),
        .expected (expected)
    );

    assign sample = (hold_cnt_q == HW'(HOLD - 1));

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pattern_d    = pattern_q;
        hold_cnt_d   = hold_cnt_q;
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_DRIVE;
                    op_d         = op;
                    pattern_d    = '0;
                    hold_cnt_d   = '0;
                    err_count_d  = '0;
                    fail_valid_d = 1'b0;
                    first_fail_d = '0;
                    pass_d       = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (sample) begin
                    if (dut_out != expected) begin
                        err_count_d = err_count_q + (N+1)'(1);
                        if (!fail_valid_q) begin
                            fail_valid_d = 1'b1;
                            first_fail_d = pattern_q;
                        end
                    end
                    if (pattern_q == LAST_PATTERN) begin
                        state_d = ST_DONE;
                        // Pass must already be valid in the DONE cycle.
                        pass_d  = (err_count_d == '0);
                    end else begin
                        pattern_d  = pattern_q + N'(1);
                        hold_cnt_d = '0;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            op_q         <= 3'd0;
            pattern_q    <= '0;
            hold_cnt_q   <= '0;
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pattern_q    <= pattern_d;
            hold_cnt_q   <= hold_cnt_d;
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
        end
    end

    assign dut_in     = pattern_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_DONE);
    assign pass       = pass_q;
    assign err_count  = err_count_q;
    assign fail_valid = fail_valid_q;
    assign first_fail = first_fail_q;

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable, parametrised stimulus-and-check engine for N-input reduction gates. It sweeps every input combination 0 … 2^N−1 into a gate under test and holds each pattern for a programmable number of cycles. On the last hold cycle it compares the gate output against a built-in reference for the selected operation, and it reports pass/fail, an error count and the first failing pattern. It replaces hand-written per-gate exhaustive benches and can also run on-board as a built-in self-test around gate-level library cells.

## Interface
- N, default 2: number of gate inputs, legal range 1..16.
- HOLD, default 5: cycles each pattern is held, legal range ≥1.
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle request to begin a sweep.
- op  input  3  expected function: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR; codes 6 and 7 behave as XOR.
- dut_in  output  N  registered pattern driven to the gate under test.
- dut_out  input  1  gate response, combinational from dut_in.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when the sweep completes.
- pass  output  1  valid from done onward: high iff err_count == 0.
- err_count  output  N+1  number of mismatching patterns.
- fail_valid  output  1  high once any mismatch is recorded.
- first_fail  output  N  pattern of the first mismatch.

## Operation
- FSM states: IDLE, DRIVE, DONE.
- IDLE → DRIVE when start=1.
  - On this transition: latch op into op_q, set pattern=0, set hold_cnt=0, clear err_count, fail_valid, first_fail and pass.
- DRIVE:
  - dut_in = pattern.
  - hold_cnt increments each cycle.
  - When hold_cnt == HOLD−1 (sample cycle), compare dut_out with ref(pattern, op_q).
  - On a mismatch, err_count increments by 1. If fail_valid=0, also capture first_fail=pattern and set fail_valid=1.
  - On the sample cycle with pattern == 2^N−1, go to DONE. Otherwise pattern increments and hold_cnt resets to 0.
- DONE:
  - done=1 for one cycle.
  - pass = (final err_count == 0).
  - Go to IDLE.
- Results (pass, err_count, fail_valid, first_fail) hold until the next accepted start or reset.
- start is ignored while busy=1 (DRIVE or DONE). Changes to op mid-sweep have no effect.
- Reference function ref: AND, OR and XOR reductions of pattern, plus their inversions for codes 3–5.
- err_count is N+1 bits and cannot overflow, because its maximum is 2^N.

## Timing
- Reset values: every output is 0, and the FSM is in IDLE.
- Reset mid-sweep aborts immediately. All outputs return to 0 and no done pulse is issued.
- Start is accepted on edge E; pattern 0 appears on dut_in after edge E.
- Each pattern occupies exactly HOLD cycles.
- The sample of the last pattern happens in cycle 2^N·HOLD after E. done is high in the following cycle (the DONE state), together with the final pass value.
- HOLD=1: the sample occurs in the same cycle the pattern is driven. This is legal only because dut_out is combinational.
- busy is high from the cycle after E through the DONE cycle inclusive.

## Structure
- Shared package gate_pkg holds:
  - the op_t encoding (3-bit enum, the six codes above);
  - the state_t enum;
  - a function gate_ref(pattern, op) returning the expected bit.
- One natural sub-module, gate_ref_model: a combinational reduction selected by op. It can be reused by other benches as a golden model.
- The top module contains the FSM, the pattern and hold counters, and the result registers.

## Test plan
- N=2, HOLD=5, op=XOR, DUT = 2-input XOR gate; start pulse → dut_in steps 00, 01, 10, 11 at 5-cycle intervals. done is high in cycle 21 after start, with pass=1, err_count=0, fail_valid=0.
- Same DUT, op=AND → mismatches on patterns 01, 10 and 11. At done: err_count=3, first_fail=01, fail_valid=1, pass=0.
- N=3, HOLD=1, DUT output stuck at 0, op=XOR → err_count=4 and first_fail=001 at done. done is high in cycle 9 after start.
- N=2, HOLD=5: assert rst in cycle 8 of a sweep → all outputs are 0 within the same cycle and no done pulse follows. A subsequent start runs a full clean sweep.
- Pulse start again while busy, and change op mid-sweep → dut_in sequence and results are unchanged, and exactly one done pulse is produced.
- op=7 with an XOR DUT → pass=1, the same result as op=2.
